// File: rtl/vproc_arb_pkg.sv
// Shared definitions for the VProc two-port memory arbiter: FSM encoding,
// default memory geometry and the segment-decode helper.
package vproc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_MEM_AW = 10;
    localparam logic [3:0]  DEF_SEG    = 4'ha;
    localparam int unsigned NUM_PORTS  = 2;

    function automatic logic seg_hit(input logic [31:0] addr, input logic [3:0] seg);
        return addr[31:28] == seg;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with a "last granted" register that
// advances only when the owner strobes in the port it actually served.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_idx_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (upd_i) begin
            last_d = upd_idx_i;
        end
    end

    always_comb begin
        gnt_valid_o = |req_i;
        unique case (req_i)
            2'b11:   gnt_idx_o = ~last_q;
            2'b10:   gnt_idx_o = 1'b1;
            default: gnt_idx_o = 1'b0;
        endcase
    end

    // Reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/vproc_mem_arbiter.sv
// Shares one single-ported memory between two VProc masters using a fixed
// IDLE -> ACCESS -> ACK sequence per access with round-robin tie breaking.
module vproc_mem_arbiter
    import vproc_arb_pkg::*;
#(
    parameter int unsigned MEM_AW = DEF_MEM_AW,
    parameter logic [3:0]  SEG    = DEF_SEG
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       Addr0,
    input  logic [31:0]       Addr1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic              RD0,
    input  logic              RD1,
    input  logic [31:0]       DataOut0,
    input  logic [31:0]       DataOut1,
    output logic [31:0]       DataIn0,
    output logic [31:0]       DataIn1,
    output logic              WRAck0,
    output logic              WRAck1,
    output logic              RDAck0,
    output logic              RDAck1,
    output logic [MEM_AW-1:0] MemA,
    output logic              MemWE,
    output logic              MemCS,
    output logic [31:0]       MemDI,
    input  logic [31:0]       MemDO
);

    arb_state_e            state_q, state_d;
    logic                  port_q, port_d;
    logic [MEM_AW-1:0]     addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  is_wr_q, is_wr_d;
    logic                  hit_q, hit_d;
    logic [31:0]           din0_q, din0_d;
    logic [31:0]           din1_q, din1_d;
    logic [NUM_PORTS-1:0]  wr_ack_q, wr_ack_d;
    logic [NUM_PORTS-1:0]  rd_ack_q, rd_ack_d;

    logic [NUM_PORTS-1:0]  req;
    logic                  gnt_valid;
    logic                  gnt_idx;
    logic                  upd;
    logic [31:0]           sel_addr;
    logic [31:0]           rdata;
    logic                  unused_addr;

    assign req = {WE1 | RD1, WE0 | RD0};

    rr_arb2 u_rr_arb2 (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .req_i       (req),
        .upd_i       (upd),
        .upd_idx_i   (port_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    assign sel_addr    = gnt_idx ? Addr1 : Addr0;
    assign unused_addr = ^sel_addr;
    // Out-of-segment reads return zero rather than whatever the memory drives.
    assign rdata       = hit_q ? MemDO : 32'd0;

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        is_wr_d  = is_wr_q;
        hit_d    = hit_q;
        din0_d   = din0_q;
        din1_d   = din1_q;
        wr_ack_d = wr_ack_q;
        rd_ack_d = rd_ack_q;
        upd      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    port_d  = gnt_idx;
                    addr_d  = sel_addr[MEM_AW-1:0];
                    wdata_d = gnt_idx ? DataOut1 : DataOut0;
                    // WE wins when a port raises both WE and RD.
                    is_wr_d = gnt_idx ? WE1 : WE0;
                    hit_d   = seg_hit(sel_addr, SEG);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (is_wr_q) begin
                    wr_ack_d[port_q] = 1'b1;
                end else begin
                    rd_ack_d[port_q] = 1'b1;
                    if (port_q) begin
                        din1_d = rdata;
                    end else begin
                        din0_d = rdata;
                    end
                end
                upd     = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                wr_ack_d = '0;
                rd_ack_d = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            port_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            is_wr_q  <= 1'b0;
            hit_q    <= 1'b0;
            din0_q   <= '0;
            din1_q   <= '0;
            wr_ack_q <= '0;
            rd_ack_q <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            is_wr_q  <= is_wr_d;
            hit_q    <= hit_d;
            din0_q   <= din0_d;
            din1_q   <= din1_d;
            wr_ack_q <= wr_ack_d;
            rd_ack_q <= rd_ack_d;
        end
    end

    assign MemA  = addr_q;
    assign MemDI = wdata_q;
    assign MemCS = (state_q == ST_ACCESS) & hit_q;
    // Reset gates the strobe combinationally so an interrupted access never writes.
    assign MemWE = MemCS & is_wr_q & ~Reset;

    assign DataIn0 = din0_q;
    assign DataIn1 = din1_q;
    assign WRAck0  = wr_ack_q[0];
    assign WRAck1  = wr_ack_q[1];
    assign RDAck0  = rd_ack_q[0];
    assign RDAck1  = rd_ack_q[1];

endmodule
